count_monitor: RTL and testbench

Downstream consumer of the 4-bit up counter. Samples the counter's `out` bus every enabled cycle, classifies each step (normal, hold, wrap, counter reset, skip), and keeps a running wrap count. Queues one record per notable event in a small show-ahead FIFO with a valid/ready output. Gives the next stage, or a bench scoreboard, a lossless-where-possible log of counter behaviour.

---
 rtl/count_monitor.sv | 68 ++++++
 tb/tb_count_monitor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// count_monitor: classifies counter steps and queues wrap/reset/skip records in a show-ahead FIFO
module count_monitor #(
  parameter int CNT_W = 4,
  parameter int WRAP_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      cnt_en,
  input  logic [CNT_W-1:0]          cnt_in,
  output logic                      ev_valid,
  input  logic                      ev_ready,
  output logic [2+CNT_W+WRAP_W-1:0] ev_data,
  output logic [WRAP_W-1:0]         wrap_count,
  output logic                      err_sticky,
  output logic                      overflow
);
  localparam int DW = 2 + CNT_W + WRAP_W;
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, TRACK} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] prev;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] used;
  logic hold, normal, wrap, creset, ev, push, pop, full;
  logic [1:0] typ;
  logic [WRAP_W-1:0] wrap_nxt;
  always_comb begin
    state_nxt = cnt_en ? TRACK : state;
    hold = cnt_in == prev;
    normal = prev != '1 && cnt_in == prev + 1'b1;
    wrap = prev == '1 && cnt_in == '0;
    creset = cnt_in == '0 && prev != '0 && prev != '1;
    ev = state == TRACK && cnt_en && !hold && !normal;
    typ = wrap ? 2'b01 : creset ? 2'b10 : 2'b11;
    wrap_nxt = wrap_count + WRAP_W'(ev && wrap);
    full = used == (AW+1)'(DEPTH);
    ev_valid = used != '0;
    ev_data = ev_valid ? mem[rd_ptr] : '0;
    pop = ev_valid && ev_ready;
    push = ev && (!full || pop);
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= IDLE;
      prev <= '0;
      wrap_count <= '0;
      err_sticky <= 1'b0;
      overflow <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      used <= '0;
    end else begin
      state <= state_nxt;
      if (cnt_en) prev <= cnt_in;
      wrap_count <= wrap_nxt;
      if (ev && typ == 2'b11) err_sticky <= 1'b1;
      if (ev && !push) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      used <= used + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {typ, wrap_nxt, cnt_in};
endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: directed self-checking bench for count_monitor
module tb_count_monitor;
  logic clk, rst, clr, cnt_en, ev_ready, ev_valid, err_sticky, overflow;
  logic [3:0] cnt_in;
  logic [13:0] ev_data;
  logic [7:0] wrap_count;
  int checks = 0;
  int errors = 0;
  count_monitor dut (
    .clk(clk), .rst(rst), .clr(clr), .cnt_en(cnt_en), .cnt_in(cnt_in),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
    .wrap_count(wrap_count), .err_sticky(err_sticky), .overflow(overflow)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] v);
    cnt_in = v;
    tick();
  endtask
  task automatic pulse_clr();
    cnt_en = 0;
    clr = 1;
    tick();
    clr = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", ev_valid); end
    checks++; if (ev_data !== 14'h0) begin errors++; $display("FAIL reset_data got %h want 0", ev_data); end
    checks++; if (wrap_count !== 8'h0) begin errors++; $display("FAIL reset_wrap got %h want 0", wrap_count); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err_sticky); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
  endtask
  task automatic test_wrap();
    int seen = 0;
    cnt_en = 1;
    ev_ready = 1;
    for (int i = 0; i < 16; i++) begin
      drive(4'(i));
      seen += int'(ev_valid);
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL wrap_early got %0d want 0", seen); end
    drive(0);
    checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %0b want 1", ev_valid); end
    checks++; if (ev_data !== {2'b01, 8'h01, 4'h0}) begin errors++; $display("FAIL wrap_data got %h want %h", ev_data, {2'b01, 8'h01, 4'h0}); end
    checks++; if (wrap_count !== 8'h01) begin errors++; $display("FAIL wrap_count got %h want 01", wrap_count); end
    drive(1);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL wrap_pop got %0b want 0", ev_valid); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL wrap_err got %0b want 0", err_sticky); end
  endtask
  task automatic test_counter_reset();
    pulse_clr();
    cnt_en = 1;
    ev_ready = 1;
    for (int i = 0; i <= 5; i++) drive(4'(i));
    drive(0);
    checks++; if (ev_data !== {2'b10, 8'h00, 4'h0}) begin errors++; $display("FAIL creset_data got %h want %h", ev_data, {2'b10, 8'h00, 4'h0}); end
    drive(1);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL creset_next got %0b want 0", ev_valid); end
  endtask
  task automatic test_skip();
    pulse_clr();
    cnt_en = 1;
    ev_ready = 1;
    for (int i = 0; i <= 3; i++) drive(4'(i));
    drive(7);
    checks++; if (ev_data !== {2'b11, 8'h00, 4'h7}) begin errors++; $display("FAIL skip_data got %h want %h", ev_data, {2'b11, 8'h00, 4'h7}); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL skip_err got %0b want 1", err_sticky); end
    drive(8);
    drive(9);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL skip_after got %0b want 0", ev_valid); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL skip_hold got %0b want 1", err_sticky); end
    pulse_clr();
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL skip_clr got %0b want 0", err_sticky); end
  endtask
  task automatic test_gap();
    pulse_clr();
    cnt_en = 1;
    ev_ready = 1;
    drive(3);
    drive(4);
    cnt_en = 0;
    drive(9);
    drive(0);
    cnt_en = 1;
    drive(5);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL gap_valid got %0b want 0", ev_valid); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL gap_err got %0b want 0", err_sticky); end
  endtask
  task automatic test_overflow();
    pulse_clr();
    ev_ready = 0;
    cnt_en = 1;
    drive(15);
    for (int w = 1; w <= 5; w++) begin
      drive(0);
      if (w == 4) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %0b want 0", overflow); end
      end
      if (w < 5) for (int v = 1; v < 16; v++) drive(4'(v));
    end
    checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %0b want 1", ev_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    checks++; if (wrap_count !== 8'h05) begin errors++; $display("FAIL ovf_wrap got %h want 05", wrap_count); end
    cnt_en = 0;
    ev_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (ev_data !== {2'b01, 8'(k), 4'h0}) begin errors++; $display("FAIL ovf_drain%0d got %h want %h", k, ev_data, {2'b01, 8'(k), 4'h0}); end
      tick();
    end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0b want 0", ev_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
  endtask
  task automatic test_back_to_back();
    pulse_clr();
    ev_ready = 0;
    cnt_en = 1;
    drive(15);
    for (int w = 1; w <= 4; w++) begin
      drive(0);
      for (int v = 1; v < 16; v++) drive(4'(v));
    end
    ev_ready = 1;
    drive(0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %0b want 0", overflow); end
    checks++; if (wrap_count !== 8'h05) begin errors++; $display("FAIL b2b_wrap got %h want 05", wrap_count); end
    cnt_en = 0;
    for (int k = 2; k <= 5; k++) begin
      checks++; if (ev_data !== {2'b01, 8'(k), 4'h0}) begin errors++; $display("FAIL b2b_drain%0d got %h want %h", k, ev_data, {2'b01, 8'(k), 4'h0}); end
      tick();
    end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b want 0", ev_valid); end
  endtask
  task automatic test_rst_midflight();
    pulse_clr();
    ev_ready = 0;
    cnt_en = 1;
    for (int i = 0; i <= 5; i++) drive(4'(i));
    drive(0);
    for (int v = 1; v < 16; v++) drive(4'(v));
    checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got %0b want 1", ev_valid); end
    rst = 1;
    drive(15);
    rst = 0;
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b want 0", ev_valid); end
    checks++; if (ev_data !== 14'h0) begin errors++; $display("FAIL mid_data got %h want 0", ev_data); end
    checks++; if (wrap_count !== 8'h0 || err_sticky !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL mid_flags got %h/%0b/%0b want 00/0/0", wrap_count, err_sticky, overflow); end
    drive(0);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL mid_nowrap got %0b want 0", ev_valid); end
    checks++; if (wrap_count !== 8'h0) begin errors++; $display("FAIL mid_wrap got %h want 00", wrap_count); end
    drive(2);
    checks++; if (ev_data !== {2'b11, 8'h00, 4'h2}) begin errors++; $display("FAIL mid_track got %h want %h", ev_data, {2'b11, 8'h00, 4'h2}); end
  endtask
  initial begin
    rst = 1;
    clr = 0;
    cnt_en = 0;
    cnt_in = 0;
    ev_ready = 0;
    test_reset();
    test_wrap();
    test_counter_reset();
    test_skip();
    test_gap();
    test_overflow();
    test_back_to_back();
    test_rst_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
